// File: rtl/cr16_controller.sv
// Multicycle control unit for the 16-bit CR16-subset core: fetches into an internal IR,
// sequences FETCH/DECODE/EXEC/MEM states and drives every datapath select and enable.
`timescale 1ns/1ps
module cr16_controller #(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   mem_rdata,
   input  logic               mem_ready,
   input  logic [7:0]         PSR,
   output logic               mem_req,
   output logic               mem_we,
   output logic               mem_addrSel,
   output logic               irWrite,
   output logic               pcWrite,
   output logic               regWrite,
   output logic               memToReg,
   output logic               alusrca,
   output logic               alusrcb,
   output logic               shiftOrALU,
   output logic               ALUselect,
   output logic [3:0]         aluControl,
   output logic               shiftType,
   output logic [WIDTH-1:0]   shiftDirection,
   output logic               jumpEN,
   output logic               jalEN,
   output logic [REGBITS-1:0] regAddress1,
   output logic [REGBITS-1:0] regAddress2,
   output logic [WIDTH-1:0]   immediate,
   output logic               illegal
);

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_CMP = 4'b0101;
   localparam logic [3:0] ALU_MOV = 4'b0110;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC_ALU, EXEC_SH, MEM_RD, MEM_WR, BRANCH, JUMP
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU, CL_SHIFT, CL_LOAD, CL_STORE, CL_JCOND, CL_JAL, CL_BRANCH, CL_ILLEGAL
   } iclass_t;

   state_t           state, state_next;
   iclass_t          iclass;
   logic [WIDTH-1:0] ir;
   logic [3:0]       op, ext, cond;
   logic [3:0]       alu_ctl;
   logic             use_imm, shift_imm, shift_arith, cond_true;
   logic [WIDTH-1:0] imm8, imm5;
   logic [4:0]       r_map, i_map;
   logic             unused_psr_bits;

   assign op   = ir[15:12];
   assign ext  = ir[7:4];
   assign cond = ir[11:8];
   assign imm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};
   assign imm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};

   // L and the undefined flag bits are not consulted by any condition code.
   assign unused_psr_bits = ^PSR[4:1];

   // Same code table serves R-type (keyed by ext) and I-type (keyed by op): {valid, ctl}.
   function automatic logic [4:0] alu_map(input logic [3:0] code);
      case (code)
         4'b0101: return {1'b1, ALU_ADD};
         4'b1001: return {1'b1, ALU_SUB};
         4'b0001: return {1'b1, ALU_AND};
         4'b0010: return {1'b1, ALU_OR};
         4'b0011: return {1'b1, ALU_XOR};
         4'b1011: return {1'b1, ALU_CMP};
         4'b1101: return {1'b1, ALU_MOV};
         default: return 5'b0_0000;
      endcase
   endfunction

   // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
   always_comb begin
      iclass  = CL_ILLEGAL;
      alu_ctl = ALU_ADD;
      use_imm = 1'b0;
      r_map   = alu_map(ext);
      i_map   = alu_map(op);
      case (op)
         4'b0000: if (r_map[4]) begin
            iclass  = CL_ALU;
            alu_ctl = r_map[3:0];
         end
         4'b1000: if (ext == 4'b0100 || ext == 4'b0110 || ext[3:2] == 2'b00) iclass = CL_SHIFT;
         4'b0100: case (ext)
            4'b0000: iclass = CL_LOAD;
            4'b0100: iclass = CL_STORE;
            4'b1100: iclass = CL_JCOND;
            4'b1000: iclass = CL_JAL;
            default: iclass = CL_ILLEGAL;
         endcase
         4'b1100: iclass = CL_BRANCH;
         default: if (i_map[4]) begin
            iclass  = CL_ALU;
            alu_ctl = i_map[3:0];
            use_imm = 1'b1;
         end
      endcase
   end

   assign shift_imm   = (ext[3:2] == 2'b00);
   assign shift_arith = (ext == 4'b0110) || (ext[3:1] == 3'b001);

   always_comb begin
      case (cond)
         4'b0000: cond_true = PSR[6];
         4'b0001: cond_true = !PSR[6];
         4'b0010: cond_true = PSR[0];
         4'b0011: cond_true = !PSR[0];
         4'b0110: cond_true = PSR[7];
         4'b0111: cond_true = !PSR[7];
         4'b1000: cond_true = PSR[5];
         4'b1001: cond_true = !PSR[5];
         4'b1100: cond_true = !PSR[7] && !PSR[6];
         4'b1101: cond_true = PSR[7] || PSR[6];
         4'b1110: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   // NOTE: the IR is reset because its fields drive outputs directly and must decode cleanly.
   always_ff @(posedge clk) begin
      if (reset)        ir <= '0;
      else if (irWrite) ir <= mem_rdata;
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH:  if (mem_ready) state_next = DECODE;
         DECODE: case (iclass)
            CL_ALU:            state_next = EXEC_ALU;
            CL_SHIFT:          state_next = EXEC_SH;
            CL_LOAD:           state_next = MEM_RD;
            CL_STORE:          state_next = MEM_WR;
            CL_BRANCH:         state_next = BRANCH;
            CL_JCOND, CL_JAL:  state_next = JUMP;
            default:           state_next = FETCH;
         endcase
         MEM_RD, MEM_WR: if (mem_ready) state_next = FETCH;
         default:        state_next = FETCH;
      endcase
   end

   // Outputs are forced low while reset is high so no enable fires in the reset cycle.
   always_comb begin
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addrSel    = 1'b0;
      irWrite        = 1'b0;
      pcWrite        = 1'b0;
      regWrite       = 1'b0;
      memToReg       = 1'b0;
      alusrca        = 1'b0;
      alusrcb        = 1'b0;
      shiftOrALU     = 1'b0;
      ALUselect      = 1'b0;
      aluControl     = ALU_ADD;
      shiftType      = 1'b0;
      shiftDirection = '0;
      jumpEN         = 1'b0;
      jalEN          = 1'b0;
      regAddress1    = '0;
      regAddress2    = '0;
      immediate      = '0;
      illegal        = 1'b0;
      if (!reset) begin
         regAddress1 = ir[8 +: REGBITS];
         regAddress2 = ir[0 +: REGBITS];
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  irWrite    = 1'b1;
                  pcWrite    = 1'b1;
                  alusrcb    = 1'b1;
                  immediate  = WIDTH'(1);
                  shiftOrALU = 1'b1;
               end
            end
            DECODE: illegal = (iclass == CL_ILLEGAL);
            EXEC_ALU: begin
               alusrca    = 1'b1;
               shiftOrALU = 1'b1;
               aluControl = alu_ctl;
               regWrite   = (alu_ctl != ALU_CMP);
               if (use_imm) begin
                  alusrcb   = 1'b1;
                  immediate = imm8;
               end
            end
            EXEC_SH: begin
               alusrca   = 1'b1;
               regWrite  = 1'b1;
               shiftType = shift_arith;
               if (shift_imm) begin
                  alusrcb        = 1'b1;
                  immediate      = imm5;
                  shiftDirection = imm5;
               end
            end
            MEM_RD: begin
               mem_req     = 1'b1;
               mem_addrSel = 1'b1;
               regWrite    = mem_ready;
               memToReg    = mem_ready;
            end
            MEM_WR: begin
               mem_req     = 1'b1;
               mem_we      = 1'b1;
               mem_addrSel = 1'b1;
            end
            BRANCH: if (cond_true) begin
               alusrcb   = 1'b1;
               immediate = imm8;
               pcWrite   = 1'b1;
            end
            JUMP: begin
               ALUselect = 1'b1;
               jumpEN    = 1'b1;
               if (iclass == CL_JAL) begin
                  jalEN    = 1'b1;
                  pcWrite  = 1'b1;
                  regWrite = 1'b1;
               end else begin
                  pcWrite  = cond_true;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cr16_controller.sv
// Scoreboard bench for cr16_controller: each task queues the expected output vector per cycle
// and the common step task pops and compares it once the DUT outputs have settled.
`timescale 1ns/1ps
module tb_cr16_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [7:0]  PSR;
   logic        mem_req, mem_we, mem_addrSel, irWrite, pcWrite, regWrite, memToReg;
   logic        alusrca, alusrcb, shiftOrALU, ALUselect, shiftType, jumpEN, jalEN, illegal;
   logic [3:0]  aluControl, regAddress1, regAddress2;
   logic [15:0] shiftDirection, immediate;

   typedef struct packed {
      logic        mem_req, mem_we, mem_addrSel, irWrite, pcWrite, regWrite, memToReg;
      logic        alusrca, alusrcb, shiftOrALU, ALUselect;
      logic [3:0]  aluControl;
      logic        shiftType;
      logic [15:0] shiftDirection;
      logic        jumpEN, jalEN;
      logic [3:0]  ra1, ra2;
      logic [15:0] immediate;
      logic        illegal;
   } outs_t;

   outs_t       exp_q[$];
   logic [15:0] ir_m;
   int          checks = 0;
   int          errors = 0;

   cr16_controller #(.WIDTH(16), .REGBITS(4)) dut (
      .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .PSR(PSR),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addrSel(mem_addrSel), .irWrite(irWrite),
      .pcWrite(pcWrite), .regWrite(regWrite), .memToReg(memToReg), .alusrca(alusrca),
      .alusrcb(alusrcb), .shiftOrALU(shiftOrALU), .ALUselect(ALUselect),
      .aluControl(aluControl), .shiftType(shiftType), .shiftDirection(shiftDirection),
      .jumpEN(jumpEN), .jalEN(jalEN), .regAddress1(regAddress1), .regAddress2(regAddress2),
      .immediate(immediate), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   function automatic outs_t sample();
      outs_t o;
      o.mem_req = mem_req;       o.mem_we = mem_we;           o.mem_addrSel = mem_addrSel;
      o.irWrite = irWrite;       o.pcWrite = pcWrite;         o.regWrite = regWrite;
      o.memToReg = memToReg;     o.alusrca = alusrca;         o.alusrcb = alusrcb;
      o.shiftOrALU = shiftOrALU; o.ALUselect = ALUselect;     o.aluControl = aluControl;
      o.shiftType = shiftType;   o.shiftDirection = shiftDirection;
      o.jumpEN = jumpEN;         o.jalEN = jalEN;             o.ra1 = regAddress1;
      o.ra2 = regAddress2;       o.immediate = immediate;     o.illegal = illegal;
      return o;
   endfunction

   function automatic logic [15:0] sext8(input logic [15:0] x);
      return {{8{x[7]}}, x[7:0]};
   endfunction

   function automatic outs_t base();
      outs_t e = '0;
      e.ra1 = ir_m[11:8];
      e.ra2 = ir_m[3:0];
      return e;
   endfunction

   function automatic outs_t fetch_exp(input logic rdy);
      outs_t e = base();
      e.mem_req = 1'b1;
      if (rdy) begin
         e.irWrite = 1'b1; e.pcWrite = 1'b1; e.alusrcb = 1'b1;
         e.immediate = 16'h0001; e.shiftOrALU = 1'b1;
      end
      return e;
   endfunction

   // One clock cycle: drive inputs just after the rising edge, compare mid-cycle.
   task automatic step(input string name, input logic rdy, input logic [15:0] rdata,
                       input logic [7:0] psr, input logic rst);
      outs_t e, a;
      reset = rst; mem_ready = rdy; mem_rdata = rdata; PSR = psr;
      #2;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, no expected value queued", name);
      end else begin
         e = exp_q.pop_front();
         a = sample();
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic fetch(input logic [15:0] instr, input int waits, input logic [7:0] psr);
      for (int i = 0; i < waits; i++) begin
         exp_q.push_back(fetch_exp(1'b0));
         step($sformatf("fetch_wait %h", instr), 1'b0, 16'hDEAD, psr, 1'b0);
      end
      exp_q.push_back(fetch_exp(1'b1));
      step($sformatf("fetch %h", instr), 1'b1, instr, psr, 1'b0);
      ir_m = instr;
   endtask

   task automatic decode(input logic ill, input logic [7:0] psr);
      outs_t e = base();
      e.illegal = ill;
      exp_q.push_back(e);
      step($sformatf("decode %h", ir_m), 1'b1, 16'hFFFF, psr, 1'b0);
   endtask

   task automatic test_reset();
      ir_m = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('0);
         step("reset_outputs", 1'b1, 16'h1234, 8'hFF, 1'b1);
      end
      exp_q.push_back(fetch_exp(1'b0));
      step("first_fetch_after_reset", 1'b0, 16'h1234, 8'h00, 1'b0);
   endtask

   typedef struct packed {
      logic [15:0] instr;
      logic [3:0]  ctl;
      logic        rw;
      logic        use_imm;
   } alu_vec_t;

   task automatic test_alu();
      alu_vec_t tbl[11];
      outs_t    e;
      tbl = '{'{16'h0152, 4'h0, 1'b1, 1'b0}, '{16'h04B5, 4'h5, 1'b0, 1'b0},
              '{16'h0192, 4'h1, 1'b1, 1'b0}, '{16'h0312, 4'h2, 1'b1, 1'b0},
              '{16'h0324, 4'h3, 1'b1, 1'b0}, '{16'h0A35, 4'h4, 1'b1, 1'b0},
              '{16'h0BD6, 4'h6, 1'b1, 1'b0}, '{16'h53FE, 4'h0, 1'b1, 1'b1},
              '{16'hB27F, 4'h5, 1'b0, 1'b1}, '{16'hD480, 4'h6, 1'b1, 1'b1},
              '{16'h1A0F, 4'h2, 1'b1, 1'b1}};
      foreach (tbl[i]) begin
         fetch(tbl[i].instr, 0, 8'h00);
         decode(1'b0, 8'h00);
         e = base();
         e.alusrca = 1'b1; e.shiftOrALU = 1'b1;
         e.aluControl = tbl[i].ctl; e.regWrite = tbl[i].rw;
         if (tbl[i].use_imm) begin
            e.alusrcb = 1'b1;
            e.immediate = sext8(tbl[i].instr);
         end
         exp_q.push_back(e);
         step($sformatf("exec_alu %h", tbl[i].instr), 1'b1, 16'hFFFF, 8'hFF, 1'b0);
      end
   endtask

   task automatic test_shift();
      logic [15:0] instr [4] = '{16'h811D, 16'h8125, 16'h8163, 16'h8143};
      logic        arith [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [15:0] amt   [4] = '{16'hFFFD, 16'h0005, 16'h0000, 16'h0000};
      logic        immf  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      outs_t e;
      foreach (instr[i]) begin
         fetch(instr[i], 0, 8'h00);
         decode(1'b0, 8'h00);
         e = base();
         e.alusrca = 1'b1; e.regWrite = 1'b1; e.shiftType = arith[i];
         e.shiftDirection = amt[i]; e.immediate = amt[i]; e.alusrcb = immf[i];
         exp_q.push_back(e);
         step($sformatf("exec_sh %h", instr[i]), 1'b1, 16'hFFFF, 8'h00, 1'b0);
      end
   endtask

   task automatic test_load_wait();
      outs_t e;
      fetch(16'h4607, 0, 8'h00);
      decode(1'b0, 8'h00);
      e = base(); e.mem_req = 1'b1; e.mem_addrSel = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(e);
         step("mem_rd_wait", 1'b0, 16'hBEEF, 8'h00, 1'b0);
      end
      e.regWrite = 1'b1; e.memToReg = 1'b1;
      exp_q.push_back(e);
      step("mem_rd_ready", 1'b1, 16'hBEEF, 8'h00, 1'b0);
   endtask

   task automatic test_store();
      outs_t e;
      fetch(16'h4547, 2, 8'h00);
      decode(1'b0, 8'h00);
      e = base(); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addrSel = 1'b1;
      exp_q.push_back(e);
      step("mem_wr_wait", 1'b0, 16'h0000, 8'h00, 1'b0);
      exp_q.push_back(e);
      step("mem_wr_ready", 1'b1, 16'h0000, 8'h00, 1'b0);
   endtask

   typedef struct packed {
      logic [15:0] instr;
      logic [7:0]  psr;
      logic        taken;
   } br_vec_t;

   task automatic test_branch();
      br_vec_t tbl[16];
      outs_t   e;
      tbl = '{'{16'hC0FD, 8'h40, 1'b1}, '{16'hC0FD, 8'h00, 1'b0}, '{16'hCFFD, 8'hFF, 1'b0},
              '{16'hC1FD, 8'h00, 1'b1}, '{16'hC205, 8'h01, 1'b1}, '{16'hC305, 8'h01, 1'b0},
              '{16'hC605, 8'h80, 1'b1}, '{16'hC705, 8'h80, 1'b0}, '{16'hC805, 8'h20, 1'b1},
              '{16'hC905, 8'h20, 1'b0}, '{16'hCC05, 8'h00, 1'b1}, '{16'hCC05, 8'h40, 1'b0},
              '{16'hCD05, 8'h40, 1'b1}, '{16'hCE05, 8'h00, 1'b1}, '{16'hC405, 8'hFF, 1'b0},
              '{16'hC005, 8'hBF, 1'b0}};
      foreach (tbl[i]) begin
         fetch(tbl[i].instr, 0, tbl[i].psr);
         decode(1'b0, tbl[i].psr);
         e = base();
         if (tbl[i].taken) begin
            e.pcWrite = 1'b1; e.alusrcb = 1'b1; e.immediate = sext8(tbl[i].instr);
         end
         exp_q.push_back(e);
         step($sformatf("branch %h psr %h", tbl[i].instr, tbl[i].psr), 1'b1, 16'hFFFF,
              tbl[i].psr, 1'b0);
      end
   endtask

   task automatic test_jump();
      logic [15:0] instr [3] = '{16'h4E89, 16'h41C9, 16'h41C9};
      logic [7:0]  psr   [3] = '{8'h40, 8'h40, 8'h00};
      logic        jal   [3] = '{1'b1, 1'b0, 1'b0};
      logic        pcw   [3] = '{1'b1, 1'b0, 1'b1};
      outs_t e;
      foreach (instr[i]) begin
         fetch(instr[i], 0, psr[i]);
         decode(1'b0, psr[i]);
         e = base();
         e.ALUselect = 1'b1; e.jumpEN = 1'b1; e.pcWrite = pcw[i];
         e.jalEN = jal[i]; e.regWrite = jal[i];
         exp_q.push_back(e);
         step($sformatf("jump %h psr %h", instr[i], psr[i]), 1'b1, 16'hFFFF, psr[i], 1'b0);
      end
   endtask

   task automatic test_illegal();
      logic [15:0] bad [8] = '{16'hF000, 16'h0100, 16'h8150, 16'h4123,
                               16'h7000, 16'hE000, 16'h6000, 16'hA000};
      foreach (bad[i]) begin
         fetch(bad[i], 0, 8'h00);
         decode(1'b1, 8'h00);
      end
      fetch(16'h0152, 0, 8'h00);
      decode(1'b0, 8'h00);
      exp_q.push_back('{default: '0, alusrca: 1'b1, shiftOrALU: 1'b1, regWrite: 1'b1,
                        ra1: 4'h1, ra2: 4'h2});
      step("exec_after_illegal", 1'b1, 16'hFFFF, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid();
      outs_t e;
      fetch(16'h4547, 0, 8'h00);
      decode(1'b0, 8'h00);
      e = base(); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addrSel = 1'b1;
      exp_q.push_back(e);
      step("mem_wr_wait_before_reset", 1'b0, 16'h0000, 8'h00, 1'b0);
      exp_q.push_back('0);
      step("reset_mid_outputs", 1'b0, 16'h0000, 8'h00, 1'b1);
      ir_m = 16'h0000;
      exp_q.push_back(fetch_exp(1'b0));
      step("fetch_after_mid_reset", 1'b0, 16'h0000, 8'h00, 1'b0);
      fetch(16'h0152, 0, 8'h00);
      decode(1'b0, 8'h00);
      e = base(); e.alusrca = 1'b1; e.shiftOrALU = 1'b1; e.regWrite = 1'b1;
      exp_q.push_back(e);
      step("exec_after_mid_reset", 1'b1, 16'hFFFF, 8'h00, 1'b0);
      exp_q.push_back(fetch_exp(1'b0));
      step("next_fetch_after_exec", 1'b0, 16'h0000, 8'h00, 1'b0);
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0; PSR = '0;
      test_reset();
      test_alu();
      test_shift();
      test_load_wait();
      test_store();
      test_branch();
      test_jump();
      test_illegal();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
